// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, jump redirects, memory-wait stalls
// with timeout. Optional performance counters are enabled by PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        ex_mem_re_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic        id_rs1_re_i,
    input  logic        id_rs2_re_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        mem_busy_i,
    output logic        stall_pc_o,
    output logic        stall_if_id_o,
    output logic        stall_id_ex_o,
    output logic        stall_ex_mem_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        mem_err_o
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StMemWait  = 2'b01,
        StJumpPend = 2'b10
    } state_e;

    localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_addr_q, pend_addr_d;

    logic        load_use;
    logic        timeout;
    logic        stall_fe_c, stall_be_c;
    logic        flush_c, jump_c, err_c, lu_stall_c;
    logic [31:0] jump_addr_c;

    assign load_use = ex_mem_re_i && (ex_rd_addr_i != 5'd0) &&
                      ((id_rs1_re_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                       (id_rs2_re_i && (id_rs2_addr_i == ex_rd_addr_i)));

    assign timeout = (state_q == StMemWait) && mem_busy_i && (cnt_q == TimeoutLast);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        stall_fe_c  = 1'b0;
        stall_be_c  = 1'b0;
        lu_stall_c  = 1'b0;
        flush_c     = 1'b0;
        jump_c      = 1'b0;
        jump_addr_c = 32'd0;
        err_c       = 1'b0;

        // On the timeout cycle busy is treated as low so the pipeline is released.
        if (mem_busy_i && !timeout) begin
            stall_fe_c = 1'b1;
            stall_be_c = 1'b1;
            state_d    = StMemWait;
            cnt_d      = cnt_q + 8'd1;
            if (jump_flag_i && !pend_q) begin
                pend_d      = 1'b1;
                pend_addr_d = jump_addr_i;
            end
        end else begin
            err_c = timeout;
            cnt_d = 8'd0;
            case (state_q)
                StIdle, StMemWait: begin
                    if ((state_q == StMemWait) && pend_q) begin
                        state_d = StJumpPend;
                    end else begin
                        state_d = StIdle;
                        if (jump_flag_i) begin
                            jump_c      = 1'b1;
                            jump_addr_c = jump_addr_i;
                            flush_c     = 1'b1;
                        end else if (load_use) begin
                            lu_stall_c = 1'b1;
                        end
                    end
                end
                StJumpPend: begin
                    jump_c      = 1'b1;
                    jump_addr_c = pend_addr_q;
                    flush_c     = 1'b1;
                    pend_d      = 1'b0;
                    state_d     = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            pend_q      <= 1'b0;
            pend_addr_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    // Outputs are forced low while reset is held, independent of the inputs.
    assign stall_pc_o     = !rst && (stall_fe_c || lu_stall_c);
    assign stall_if_id_o  = !rst && (stall_fe_c || lu_stall_c);
    assign stall_id_ex_o  = !rst && stall_be_c;
    assign stall_ex_mem_o = !rst && stall_be_c;
    assign flush_if_id_o  = !rst && flush_c;
    assign flush_id_ex_o  = !rst && (flush_c || lu_stall_c);
    assign jump_flag_o    = !rst && jump_c;
    assign jump_addr_o    = (!rst && jump_c) ? jump_addr_c : 32'd0;
    assign mem_err_o      = !rst && err_c;

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, stall_pc_o};
        flush_cnt_d = flush_cnt_q + {31'd0, flush_id_ex_o};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    // Without the counters the interface above is complete.
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table, directed multi-cycle sequences and
// randomized traffic against a queue-based reference model.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = 32'd0;
    logic        ex_mem_re_i = 1'b0;
    logic [4:0]  ex_rd_addr_i = 5'd0;
    logic        id_rs1_re_i = 1'b0;
    logic        id_rs2_re_i = 1'b0;
    logic [4:0]  id_rs1_addr_i = 5'd0;
    logic [4:0]  id_rs2_addr_i = 5'd0;
    logic        mem_busy_i = 1'b0;
    logic        stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o;
    logic        flush_if_id_o, flush_id_ex_o, jump_flag_o, mem_err_o;
    logic [31:0] jump_addr_o;

    int checks = 0;
    int errors = 0;

    localparam int unsigned Timeout = 16;

    pipe_ctrl #(.MEM_TIMEOUT(Timeout)) dut (
        .clk            (clk),
        .rst            (rst),
        .jump_flag_i    (jump_flag_i),
        .jump_addr_i    (jump_addr_i),
        .ex_mem_re_i    (ex_mem_re_i),
        .ex_rd_addr_i   (ex_rd_addr_i),
        .id_rs1_re_i    (id_rs1_re_i),
        .id_rs2_re_i    (id_rs2_re_i),
        .id_rs1_addr_i  (id_rs1_addr_i),
        .id_rs2_addr_i  (id_rs2_addr_i),
        .mem_busy_i     (mem_busy_i),
        .stall_pc_o     (stall_pc_o),
        .stall_if_id_o  (stall_if_id_o),
        .stall_id_ex_o  (stall_id_ex_o),
        .stall_ex_mem_o (stall_ex_mem_o),
        .flush_if_id_o  (flush_if_id_o),
        .flush_id_ex_o  (flush_id_ex_o),
        .jump_flag_o    (jump_flag_o),
        .jump_addr_o    (jump_addr_o),
        .mem_err_o      (mem_err_o)
    );

    always #5 clk = ~clk;

    // {stall pc,if_id,id_ex,ex_mem, flush if_id,id_ex, jump_flag, mem_err, jump_addr}
    function automatic logic [39:0] mk(logic [3:0] st, logic [1:0] fl, logic jf, logic err,
                                       logic [31:0] a);
        return {st, fl, jf, err, a};
    endfunction

    function automatic logic [39:0] obs();
        return {stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o,
                flush_if_id_o, flush_id_ex_o, jump_flag_o, mem_err_o, jump_addr_o};
    endfunction

    task automatic check(input string name, input logic [39:0] exp);
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, obs(), exp);
        end
    endtask

    task automatic set_in(input logic jf, input logic [31:0] ja, input logic re,
                          input logic [4:0] rd, input logic r1e, input logic [4:0] r1,
                          input logic r2e, input logic [4:0] r2, input logic busy);
        jump_flag_i   = jf;
        jump_addr_i   = ja;
        ex_mem_re_i   = re;
        ex_rd_addr_i  = rd;
        id_rs1_re_i   = r1e;
        id_rs1_addr_i = r1;
        id_rs2_re_i   = r2e;
        id_rs2_addr_i = r2;
        mem_busy_i    = busy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Busy and jump held high while reset is asserted: outputs must still be zero.
    task automatic do_reset(input string name);
        set_in(1'b1, 32'hdead_beef, 1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1);
        rst = 1'b1;
        #1;
        check(name, 40'd0);
        @(posedge clk);
        set_in(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        rst_before;
        logic        jf;
        logic [31:0] ja;
        logic        re;
        logic [4:0]  rd;
        logic        r1e;
        logic [4:0]  r1;
        logic        r2e;
        logic [4:0]  r2;
        logic        busy;
        logic [39:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    bit          m_wait;
    bit          m_due;
    int          m_run;
    logic [31:0] m_pend[$];

    initial begin
        vecs.push_back('{"lu_rs1", 1, 0, 0, 1, 5, 1, 5, 0, 0, 0, mk(4'b1100, 2'b01, 0, 0, 0)});
        vecs.push_back('{"lu_next", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(4'b0000, 2'b00, 0, 0, 0)});
        vecs.push_back('{"x0_nohaz", 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, mk(4'b0000, 2'b00, 0, 0, 0)});
        vecs.push_back('{"lu_rs2", 1, 0, 0, 1, 7, 0, 0, 1, 7, 0, mk(4'b1100, 2'b01, 0, 0, 0)});
        vecs.push_back('{"rs2_noread", 1, 0, 0, 1, 7, 0, 7, 0, 7, 0, mk(4'b0000, 2'b00, 0, 0, 0)});
        vecs.push_back('{"not_load", 1, 0, 0, 0, 9, 1, 9, 1, 9, 0, mk(4'b0000, 2'b00, 0, 0, 0)});
        vecs.push_back('{"jump_lu", 1, 1, 32'h100, 1, 5, 1, 5, 0, 0, 0,
                         mk(4'b0000, 2'b11, 1, 0, 32'h100)});
        vecs.push_back('{"busy", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk(4'b1111, 2'b00, 0, 0, 0)});
        vecs.push_back('{"busy_jump_lu", 1, 1, 32'h44, 1, 2, 1, 2, 0, 0, 1,
                         mk(4'b1111, 2'b00, 0, 0, 0)});

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) do_reset("reset_out");
            set_in(vecs[i].jf, vecs[i].ja, vecs[i].re, vecs[i].rd, vecs[i].r1e, vecs[i].r1,
                   vecs[i].r2e, vecs[i].r2, vecs[i].busy);
            #2;
            check(vecs[i].name, vecs[i].exp);
            tick();
        end

        // Busy for three cycles with a jump in the first, then the deferred redirect.
        do_reset("reset_out");
        for (int i = 0; i < 3; i++) begin
            set_in(i == 0, 32'h200, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
            #2;
            check("busy3_stall", mk(4'b1111, 2'b00, 0, 0, 0));
            tick();
        end
        set_in(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #2;
        check("busy3_exit", mk(4'b0000, 2'b00, 0, 0, 0));
        tick();
        #2;
        check("busy3_jpend", mk(4'b0000, 2'b11, 1, 0, 32'h200));
        tick();
        #2;
        check("busy3_idle", mk(4'b0000, 2'b00, 0, 0, 0));
        tick();

        // Busy held: error pulse and release on the 16th busy cycle, then stall again.
        do_reset("reset_out");
        set_in(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        for (int i = 1; i <= 18; i++) begin
            #2;
            if (i == Timeout) check("timeout_pulse", mk(4'b0000, 2'b00, 0, 1, 0));
            else check("timeout_stall", mk(4'b1111, 2'b00, 0, 0, 0));
            tick();
        end

        // Asynchronous reset in the middle of a wait drops the pending redirect.
        do_reset("reset_out");
        set_in(1'b1, 32'h300, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        #2;
        check("rstmid_stall", mk(4'b1111, 2'b00, 0, 0, 0));
        tick();
        #2;
        check("rstmid_stall", mk(4'b1111, 2'b00, 0, 0, 0));
        rst = 1'b1;
        #1;
        check("rstmid_async", 40'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_in(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #2;
            check("rstmid_nojump", 40'd0);
            tick();
        end

        // Randomized traffic against the reference model.
        do_reset("reset_out");
        m_wait = 0;
        m_due  = 0;
        m_run  = 0;
        m_pend.delete();
        begin
            int streak = 0;
            for (int c = 0; c < 3000; c++) begin
                logic        jf, re, r1e, r2e, busy, tmo, lu;
                logic [4:0]  rd, r1, r2;
                logic [31:0] ja;
                logic [39:0] exp;
                jf  = ($urandom_range(0, 99) < 20);
                ja  = $urandom;
                re  = $urandom_range(0, 1);
                rd  = 5'($urandom_range(0, 3));
                r1e = $urandom_range(0, 1);
                r1  = 5'($urandom_range(0, 3));
                r2e = $urandom_range(0, 1);
                r2  = 5'($urandom_range(0, 3));
                if (streak > 0) begin
                    busy = 1'b1;
                    streak--;
                end else if ($urandom_range(0, 99) < 3) begin
                    busy = 1'b1;
                    streak = $urandom_range(12, 20);
                end else begin
                    busy = ($urandom_range(0, 99) < 20);
                end
                set_in(jf, ja, re, rd, r1e, r1, r2e, r2, busy);

                lu  = re && (rd != 0) && ((r1e && r1 == rd) || (r2e && r2 == rd));
                tmo = m_wait && busy && (m_run == Timeout - 1);
                if (busy && !tmo) begin
                    exp = mk(4'b1111, 2'b00, 0, 0, 0);
                    if (jf && m_pend.size() == 0) m_pend.push_back(ja);
                    m_run++;
                    m_wait = 1;
                    m_due  = 0;
                end else if (m_due) begin
                    exp = mk(4'b0000, 2'b11, 1, 0, m_pend[0]);
                    void'(m_pend.pop_front());
                    m_due = 0;
                end else if (m_wait && m_pend.size() != 0) begin
                    exp    = mk(4'b0000, 2'b00, 0, tmo, 0);
                    m_wait = 0;
                    m_run  = 0;
                    m_due  = 1;
                end else begin
                    if (jf) exp = mk(4'b0000, 2'b11, 1, tmo, ja);
                    else if (lu) exp = mk(4'b1100, 2'b01, 0, tmo, 0);
                    else exp = mk(4'b0000, 2'b00, 0, tmo, 0);
                    m_wait = 0;
                    m_run  = 0;
                end
                #2;
                check("random", exp);
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: max consecutive mem-busy cycles before a forced release (range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 jump_flag_i  input  1  EX requests a redirect (taken branch/jal/jalr) this cycle.
REQ-005 jump_addr_i  input  32  redirect target, valid with jump_flag_i.
REQ-006 ex_mem_re_i  input  1  instruction now in EX is a load.
REQ-007 ex_rd_addr_i  input  5  destination register of the instruction in EX.
REQ-008 id_rs1_re_i / id_rs2_re_i  input  1 each  ID reads rs1/rs2.
REQ-009 id_rs1_addr_i / id_rs2_addr_i  input  5 each  ID source register addresses.
REQ-010 mem_busy_i  input  1  data memory cannot complete the access this cycle.
REQ-011 stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o  output  1 each  hold the stage register's current contents.
REQ-012 flush_if_id_o, flush_id_ex_o  output  1 each  load the stage register's NOP/zero default (drives hold_flag_i of the stage registers).
REQ-013 jump_flag_o  output  1, jump_addr_o  output  32  PC redirect to fetch.
REQ-014 mem_err_o  output  1  one-cycle pulse on memory timeout.

Function
REQ-015 States: IDLE, MEM_WAIT, JUMP_PEND; encoded in 2 bits; the fourth code returns to IDLE.
REQ-016 Load-use hazard = ex_mem_re_i & (ex_rd_addr_i != 0) & ((id_rs1_re_i & rs1 == rd) | (id_rs2_re_i & rs2 == rd)); x0 never causes a hazard.
REQ-017 IDLE, load-use, no jump, no mem_busy: same cycle assert stall_pc_o, stall_if_id_o, flush_id_ex_o; one bubble only; state stays IDLE.
REQ-018 IDLE, jump_flag_i, no mem_busy: same cycle assert jump_flag_o, jump_addr_o = jump_addr_i, flush_if_id_o, flush_id_ex_o; any simultaneous load-use is ignored (squashed).
REQ-019 mem_busy_i in any state has highest priority: assert all four stall outputs, deassert both flush outputs and jump_flag_o, next state MEM_WAIT.
REQ-020 jump_flag_i coincident with mem_busy_i: latch jump_addr_i into a pending register and set pending bit; redirect is not lost.
REQ-021 MEM_WAIT: 8-bit counter increments each busy cycle; all stalls held while mem_busy_i high.
REQ-022 MEM_WAIT exit on mem_busy_i low: to JUMP_PEND if pending bit set, else IDLE; counter cleared.
REQ-023 Counter reaching MEM_TIMEOUT-1 with mem_busy_i still high: pulse mem_err_o for one cycle, release stalls, exit as REQ-022 regardless of mem_busy_i, busy ignored for that one exit cycle.
REQ-024 JUMP_PEND lasts exactly one cycle: jump_flag_o = 1, jump_addr_o = pending register, flush_if_id_o and flush_id_ex_o = 1; pending bit cleared; next IDLE (mem_busy_i in this cycle still wins per REQ-019, pending kept).
REQ-025 When jump_flag_o is 0, jump_addr_o = 0.
REQ-026 Stall and flush outputs are combinational from state and current inputs; zero-cycle latency.

Reset
REQ-027 rst asserted: state IDLE, counter 0, pending bit 0, pending address 0, mem_err_o 0, immediately, without clk.
REQ-028 During reset all stall/flush/jump outputs are 0 and jump_addr_o = 0; reset mid-MEM_WAIT discards the pending jump.

Configuration
REQ-029 Macro PIPE_CTRL_PERF_CNT_EN defined: add outputs stall_cnt_o[31:0] (cycles with stall_pc_o high) and flush_cnt_o[31:0] (cycles with flush_id_ex_o high), both reset to 0, wrap 0xFFFFFFFF -> 0.
REQ-030 Macro undefined: those ports and counters do not exist; all other behaviour identical.

Verification
REQ-031 EX load rd=5, ID rs1=5 rs1_re=1 -> one cycle stall_pc/stall_if_id/flush_id_ex = 1, next cycle all 0.
REQ-032 EX load rd=0, ID rs1=0 -> no stall, no flush.
REQ-033 jump_flag_i=1, addr 0x0000_0100, plus load-use -> jump_flag_o=1, jump_addr_o=0x100, both flushes=1, stall_pc_o=0.
REQ-034 mem_busy_i high 3 cycles with jump 0x200 in first -> 3 cycles all stalls=1, then one JUMP_PEND cycle jump_addr_o=0x200, then IDLE.
REQ-035 mem_busy_i held high, MEM_TIMEOUT=16 -> mem_err_o pulses once in 16th busy cycle, stalls released that cycle.
REQ-036 rst asserted mid-MEM_WAIT with pending jump -> outputs 0 asynchronously; after release no jump issued.
